// File: rtl/gf_poly_div_if.sv
// gf_poly_div_if: start/busy/done handshake and coefficient buses for the polynomial divider
interface gf_poly_div_if #(parameter int SIZE = 8, parameter int n = 2);
    logic                        start;
    logic                        busy;
    logic                        done;
    logic                        err;
    logic [(2*n+1)*SIZE-1:0]     flat_p;
    logic [(n+1)*SIZE-1:0]       flat_q;
    logic [(2*n+1)*SIZE-1:0]     flat_quo;
    logic [n*SIZE-1:0]           flat_rem;
    modport master (output start, flat_p, flat_q, input busy, done, err, flat_quo, flat_rem);
    modport slave (input start, flat_p, flat_q, output busy, done, err, flat_quo, flat_rem);
endinterface

// File: rtl/gf_poly_div.sv
// gf_poly_div: sequential GF(2^SIZE) polynomial long divider (quotient + remainder)
module gf_mul #(parameter int SIZE = 8) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE-1:0] y
);
    localparam logic [SIZE-1:0] red = SIZE'(SIZE == 2 ? 'h7 : SIZE == 3 ? 'hb : SIZE == 4 ? 'h13 :
                                            SIZE == 5 ? 'h25 : SIZE == 6 ? 'h43 : SIZE == 7 ? 'h89 : 'h11d);
    logic [SIZE-1:0] t;
    always_comb begin
        y = '0;
        t = a;
        for (int i = 0; i < SIZE; i++) begin
            y = y ^ (b[i] ? t : '0);
            t = {t[SIZE-2:0], 1'b0} ^ (t[SIZE-1] ? red : '0);
        end
    end
endmodule

module gf_poly_div #(
    parameter int m                = 255,
    parameter int SIZE             = $clog2(m),
    parameter int n                = 2,
    parameter int flat_size        = (n+1)*SIZE,
    parameter int large_array_size = (2*n+1)*SIZE
) (
    input logic         clk,
    input logic         rst_n,
    gf_poly_div_if.slave bus
);
    typedef enum logic [1:0] {IDLE, INV, DIV, DONE} state_t;
    localparam int KW = $clog2(2*n+1);
    localparam int CW = $clog2(SIZE) + 1;
    state_t                  state_q, state_d;
    logic [2*n:0][SIZE-1:0]  r_q, r_d, q_q, q_d, quo_q, quo_d;
    logic [n:0][SIZE-1:0]    d_q, d_d, d_in, pa, prod;
    logic [n-1:0][SIZE-1:0]  rem_q, rem_d;
    logic [SIZE-1:0]         s_q, s_d, inv_q, inv_d, ma, mb, c;
    logic [KW-1:0]           k_q, k_d, dd_q, dd_d, dd_in, base;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    err_q, err_d, d_zero, last;
    assign d_in   = flat_size'(bus.flat_q);
    assign d_zero = d_q == '0;
    assign base   = k_q - dd_q;
    // k runs one below dd for a drain cycle before DONE; modular wrap keeps this valid for dd=0
    assign last   = k_q == dd_q - KW'(1);
    always_comb begin
        dd_in = '0;
        for (int i = 0; i <= n; i++)
            dd_in = (d_in[i] != '0) ? KW'(i) : dd_in;
    end
    // INV reuses the first two multipliers: s*s, then r*s_new; inv_q doubles as r
    assign ma = (state_q == INV) ? s_q : r_q[k_q];
    assign mb = (state_q == INV) ? s_q : inv_q;
    gf_mul #(.SIZE(SIZE)) u_lead (.a(ma), .b(mb), .y(c));
    for (genvar j = 0; j <= n; j++) begin : g_mul
        assign pa[j] = (j == 0 && state_q == INV) ? inv_q : d_q[j];
        gf_mul #(.SIZE(SIZE)) u_mul (.a(pa[j]), .b(c), .y(prod[j]));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            s_q     <= '0;
            inv_q   <= '0;
            k_q     <= '0;
            dd_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            s_q     <= s_d;
            inv_q   <= inv_d;
            k_q     <= k_d;
            dd_q    <= dd_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end
    // a zero divisor is detected from the latched D in the first INV cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.start ? INV : IDLE;
            INV:     state_d = d_zero ? DONE : (cnt_q == CW'(SIZE-2)) ? DIV : INV;
            DIV:     state_d = last ? DONE : DIV;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        r_d   = r_q;
        q_d   = q_q;
        d_d   = d_q;
        s_d   = s_q;
        inv_d = inv_q;
        k_d   = k_q;
        dd_d  = dd_q;
        cnt_d = cnt_q;
        err_d = err_q;
        quo_d = quo_q;
        rem_d = rem_q;
        if (state_q == IDLE && bus.start) begin
            r_d   = large_array_size'(bus.flat_p);
            d_d   = d_in;
            q_d   = '0;
            err_d = 1'b0;
            dd_d  = dd_in;
            s_d   = d_in[dd_in];
            inv_d = SIZE'(1);
            cnt_d = '0;
            k_d   = KW'(2*n);
        end
        if (state_q == INV) begin
            s_d   = c;
            inv_d = prod[0];
            cnt_d = cnt_q + CW'(1);
        end
        if (state_q == DIV) begin
            for (int i = 0; i <= 2*n; i++) begin
                q_d[i] = (i == int'(base)) ? c : q_d[i];
                for (int j = 0; j <= n; j++)
                    r_d[i] = (i == int'(base) + j) ? r_d[i] ^ prod[j] : r_d[i];
            end
            k_d = k_q - KW'(1);
        end
        if (state_d == DONE) begin
            err_d = d_zero;
            quo_d = q_d;
            rem_d = d_zero ? '0 : r_d[n-1:0];
        end
    end
    assign bus.busy     = (state_q == INV && !d_zero) || state_q == DIV;
    assign bus.done     = state_q == DONE;
    assign bus.err      = err_q;
    assign bus.flat_quo = quo_q;
    assign bus.flat_rem = rem_q;
endmodule

// File: tb/tb_gf_poly_div.sv
// tb_gf_poly_div: directed scoreboard bench for gf_poly_div (GF(2^8), n=2)
module tb_gf_poly_div;
    localparam int SIZE = 8;
    localparam int N    = 2;
    typedef struct {
        logic [39:0] quo;
        logic [15:0] rem;
        logic        err;
        int          lat;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    gf_poly_div_if #(.SIZE(SIZE), .n(N)) bus ();
    gf_poly_div #(.m(255), .SIZE(SIZE), .n(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    function automatic logic [39:0] p5(logic [7:0] c0, logic [7:0] c1, logic [7:0] c2, logic [7:0] c3, logic [7:0] c4);
        return {c4, c3, c2, c1, c0};
    endfunction
    function automatic logic [23:0] p3(logic [7:0] c0, logic [7:0] c1, logic [7:0] c2);
        return {c2, c1, c0};
    endfunction
    function automatic logic [15:0] p2(logic [7:0] c0, logic [7:0] c1);
        return {c1, c0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [39:0] quo, input logic [15:0] rem, input logic err, input int lat);
        exp_t e;
        e.quo = quo;
        e.rem = rem;
        e.err = err;
        e.lat = lat;
        sb.push_back(e);
    endtask

    // drives start for exactly one edge (edge 0 of the run)
    task automatic launch(input logic [39:0] p, input logic [23:0] q);
        @(negedge clk);
        bus.flat_p = p;
        bus.flat_q = q;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_after_accept", bus.busy, q != '0);
    endtask

    task automatic finish_run(input bit poke);
        exp_t e;
        int   edges = 0;
        bit   got = 0;
        bit   busy_seen = 0;
        while (!got && edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
            if (poke) begin
                bus.start  = (edges == 9);
                bus.flat_p = (edges == 9) ? 40'hff_ee_dd_cc_bb : bus.flat_p;
                bus.flat_q = (edges == 9) ? 24'h00_01_07 : bus.flat_q;
            end
            busy_seen = busy_seen | bus.busy;
            got = bus.done;
        end
        bus.start = 1'b0;
        e = sb.pop_front();
        chk("done_seen", got, 1'b1);
        chk("latency", edges, e.lat);
        chk("quo", bus.flat_quo, e.quo);
        chk("rem", bus.flat_rem, e.rem);
        chk("err", bus.err, e.err);
        chk("busy_with_done", bus.busy, 1'b0);
        chk("busy_seen", busy_seen, !e.err);
        @(posedge clk);
        #1;
        chk("done_pulse", bus.done, 1'b0);
        chk("quo_hold", bus.flat_quo, e.quo);
        chk("err_hold", bus.err, e.err);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.flat_p = '0;
        bus.flat_q = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_quo", bus.flat_quo, 40'h0);
        chk("rst_rem", bus.flat_rem, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        // x^4+1 / x^2+1
        push(p5(1, 0, 1, 0, 0), p2(0, 0), 1'b0, 11);
        launch(p5(1, 0, 0, 0, 1), p3(1, 0, 1));
        finish_run(1'b0);
        // x^4+x+3 / x^2+1
        push(p5(1, 0, 1, 0, 0), p2(2, 1), 1'b0, 11);
        launch(p5(3, 1, 0, 0, 1), p3(1, 0, 1));
        finish_run(1'b0);
        // x^4 / x+1
        push(p5(1, 1, 1, 1, 0), p2(1, 0), 1'b0, 12);
        launch(p5(0, 0, 0, 0, 1), p3(1, 1, 0));
        finish_run(1'b0);
        // non-monic constant divisor 2
        push(p5(3, 2, 1, 0, 0), p2(0, 0), 1'b0, 13);
        launch(p5(6, 4, 2, 0, 0), p3(2, 0, 0));
        finish_run(1'b0);
        // divide by x^2: shift down by two
        push(p5(9, 11, 13, 0, 0), p2(5, 7), 1'b0, 11);
        launch(p5(5, 7, 9, 11, 13), p3(0, 0, 1));
        finish_run(1'b0);
        // divide by x: shift down by one
        push(p5(7, 9, 11, 13, 0), p2(5, 0), 1'b0, 12);
        launch(p5(5, 7, 9, 11, 13), p3(0, 1, 0));
        finish_run(1'b0);
        // zero divisor
        push(40'h0, 16'h0, 1'b1, 1);
        launch(p5(5, 7, 9, 11, 13), p3(0, 0, 0));
        finish_run(1'b0);
        // start pulsed mid-DIV with other operands is ignored
        push(p5(1, 0, 1, 0, 0), p2(2, 1), 1'b0, 11);
        launch(p5(3, 1, 0, 0, 1), p3(1, 0, 1));
        finish_run(1'b1);
        // asynchronous reset at edge 5 of a run
        launch(p5(1, 0, 0, 0, 1), p3(1, 0, 1));
        repeat (5) @(posedge clk);
        #1;
        chk("busy_before_abort", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_err", bus.err, 1'b0);
        chk("abort_quo", bus.flat_quo, 40'h0);
        chk("abort_rem", bus.flat_rem, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        push(p5(1, 1, 1, 1, 0), p2(1, 0), 1'b0, 12);
        launch(p5(0, 0, 0, 0, 1), p3(1, 1, 0));
        finish_run(1'b0);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gf_poly_div.md
Name: gf_poly_div

Overview:
- Sequential GF(2^SIZE) polynomial long divider; the inverse operation of the combinational polynomial multiplier.
- Accepts a degree-2n dividend and a degree-≤n divisor, in the same flat coefficient packing the multiplier produces. Returns quotient and remainder after a multi-cycle start/busy/done sequence.
- Used by the Reed-Solomon decode path: syndrome/error-locator reduction and checking that multiplier products divide back.
- Field multiplications use the existing gf_mul instance with the same m/SIZE parameters.

Parameters:
- m, 255, field order minus one; nonzero a satisfies a^m = 1.
- SIZE, $clog2(m), coefficient width in bits.
- n, 2, divisor maximum degree; dividend degree is 2n.
- flat_size, (n+1)*SIZE, divisor bus width.
- large_array_size, (2n+1)*SIZE, dividend and quotient bus width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only in IDLE.
- flat_p  input  large_array_size  dividend; coefficient i at bits [(i+1)*SIZE-1:i*SIZE], i=0 is the constant term.
- flat_q  input  flat_size  divisor; same packing.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results become valid.
- err  output  1  divisor was all-zero; valid with done, held until the next accept.
- flat_quo  output  large_array_size  quotient, same packing.
- flat_rem  output  n*SIZE  remainder, coefficients 0..n-1.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE; busy=0, done=0, err=0; flat_quo=0, flat_rem=0; internal registers 0.
- Reset mid-operation aborts immediately to these values. No partial result is retained.
- States: IDLE, INV, DIV, DONE.
- IDLE:
  - On start=1 at edge 0: latch flat_p into the working remainder R (2n+1 coefficients) and flat_q into D; clear the quotient register Q and err.
  - dd = index of the highest nonzero coefficient of flat_q.
  - If D is all zero: go to DONE with err=1, Q=0, rem=0.
  - Otherwise go to INV with busy=1.
  - start=0 means stay in IDLE.
- INV: computes inv = lead^(m-1) = lead^-1, where lead = D[dd].
  - Initial values: s=lead, r=1.
  - Each cycle: s<=s*s, r<=r*s_new, using two gf_mul instances.
  - Exactly SIZE-1 cycles, on edges 1..SIZE-1. Result inv=r. Then go to DIV with step index k=2n.
- DIV: one step per cycle, on edges SIZE .. SIZE+2n-dd.
  - c = R[k]*inv; Q[k-dd] <= c.
  - For j=0..dd: R[k-dd+j] <= R[k-dd+j] XOR c*D[j]. This uses n+2 gf_mul instances in total; R[k] becomes 0.
  - When k==dd, go to DONE; otherwise k <= k-1.
  - c=0 steps still consume a cycle. Latency depends on dd only, not on the data.
- DONE (entered on edge SIZE+2n-dd+1, or edge 1 for a zero divisor):
  - done=1 for exactly one cycle; busy=0.
  - flat_quo <= Q; flat_rem <= R[n-1:0]. Coefficients with index ≥ dd are guaranteed 0.
  - Go to IDLE next edge. Outputs hold until the next accept or reset.
- Timing summary (m=255, SIZE=8, n=2): done is high in the cycle after edge 8+4-dd+1, i.e. edge 11/12/13 for dd=2/1/0.
- start while busy or in DONE is ignored. Inputs are sampled only at the accept edge, so later changes have no effect.
- Arithmetic: addition is XOR, multiplication is gf_mul. No widths are extended. Quotient coefficients above 2n-dd are 0.
- Back-to-back: start may be asserted in the cycle done is high. It is not accepted until IDLE (one cycle later).

Test Plan:
- Divisor x^2+1 ({1,0,1}), dividend x^4+1 ({1,0,0,0,1}) -> quo {1,0,1,0,0} (x^2+1), rem {0,0}, err=0, done on edge 11.
- Same divisor, dividend x^4+x+3 ({3,1,0,0,1}) -> quo x^2+1, rem {2,1} (x+2), done edge 11.
- Divisor x+1 ({1,1,0}), dividend x^4 -> quo {1,1,1,1,0}, rem {1,0}, done edge 12.
- Non-monic degree-0 divisor {2,0,0}, dividend {6,4,2,0,0} -> inverse path exercised.
  - Required: quo {3,2,1,0,0}, rem {0,0}, done edge 13.
- Divisor all zero, any dividend -> err=1, quo=0, rem=0, done high in the cycle after edge 1, busy never high.
- Control corner cases:
  - Pulse start mid-DIV with a different dividend -> ignored; the original result is returned.
  - Drop rst_n at edge 5 of a run -> busy, done, err and outputs go to 0 immediately (asynchronous).
  - A new start after rst_n deasserts completes normally.
